mp8_out_port: RTL and testbench

- External I/O responder for the MP-8 processor; sits outside `top` on the processor's output/input pins.
- Captures every byte the processor writes via `OutWrite`/`outToOutside` into a small FIFO and drains it to a host over a valid/ready handshake.
- Also holds the host-loaded byte presented to the processor's `inFromOutside`.
- Gives the processor's output port a real consumer instead of a bench-only probe.

---
 rtl/mp8_out_port.sv | 147 ++++++++++++++
 tb/tb_mp8_out_port.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mp8_out_port.sv
// mp8_out_port: external I/O responder for the MP-8 processor.
//
// Captures bytes written by the processor (OutWrite / outToOutside) into a
// small FIFO and drains them to a host over a valid/ready handshake. Also
// holds a host-loaded byte that is presented to the processor's
// inFromOutside input.
//
// Ports:
//   clk           system clock, rising-edge active
//   reset         asynchronous active-low reset
//   cpu_out_data  byte from processor outToOutside
//   cpu_out_write write strobe from processor OutWrite
//   cpu_in_data   byte to processor inFromOutside
//   host_in_load  load strobe for cpu_in_data
//   host_in_data  byte loaded into cpu_in_data
//   host_data     FIFO head byte (0 while empty)
//   host_valid    FIFO non-empty
//   host_ready    host accepts the head byte
//   count         current FIFO occupancy
//   full          count == DEPTH
//   overflow      sticky: a byte was dropped because the FIFO was full
//   ovf_clear     clears overflow (a simultaneous drop wins)
//
// Build option: define MP8_OUT_EDGE_EN to push only on the rising edge of
// cpu_out_write (one byte per pulse regardless of pulse length).

module mp8_out_port #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         cpu_out_data,
    input  logic                     cpu_out_write,
    output logic [WIDTH-1:0]         cpu_in_data,
    input  logic                     host_in_load,
    input  logic [WIDTH-1:0]         host_in_data,
    output logic [WIDTH-1:0]         host_data,
    output logic                     host_valid,
    input  logic                     host_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overflow,
    input  logic                     ovf_clear
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] in_q, in_d;

    logic push_req;
    logic push_ok;
    logic pop;
    logic drop;

`ifdef MP8_OUT_EDGE_EN
    // History of OutWrite so a long pulse pushes only on its first high cycle.
    logic out_write_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_write_q <= 1'b0;
        end else begin
            out_write_q <= cpu_out_write;
        end
    end

    assign push_req = cpu_out_write && !out_write_q;
`else
    assign push_req = cpu_out_write;
`endif

    assign host_valid = (count_q != '0);
    assign full       = (count_q == CW'(DEPTH));
    assign pop        = host_valid && host_ready;
    // When full, a same-edge pop frees the slot this push lands in.
    assign push_ok    = push_req && (!full || pop);
    assign drop       = push_req && full && !pop;

    // Gate the head byte so it reads 0 whenever the FIFO is empty.
    assign host_data   = host_valid ? mem_q[rptr_q] : '0;
    assign count       = count_q;
    assign overflow    = ovf_q;
    assign cpu_in_data = in_q;

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        in_d    = in_q;

        if (push_ok) begin
            mem_d[wptr_q] = cpu_out_data;
            wptr_d        = wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PW'(1);
        end

        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - CW'(1);
        end

        // A new drop on the same edge as a clear leaves the flag set.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clear) begin
            ovf_d = 1'b0;
        end

        if (host_in_load) begin
            in_d = host_in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            in_q    <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            in_q    <= in_d;
        end
    end

endmodule

// File: tb/tb_mp8_out_port.sv
// Directed self-checking bench for mp8_out_port (DEPTH=4, WIDTH=8).
module tb_mp8_out_port;

    logic       clk;
    logic       reset;
    logic [7:0] cpu_out_data;
    logic       cpu_out_write;
    logic [7:0] cpu_in_data;
    logic       host_in_load;
    logic [7:0] host_in_data;
    logic [7:0] host_data;
    logic       host_valid;
    logic       host_ready;
    logic [2:0] count;
    logic       full;
    logic       overflow;
    logic       ovf_clear;

    int n_cmp = 0;
    int n_err = 0;

    mp8_out_port #(
        .DEPTH(4),
        .WIDTH(8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_out_data (cpu_out_data),
        .cpu_out_write(cpu_out_write),
        .cpu_in_data  (cpu_in_data),
        .host_in_load (host_in_load),
        .host_in_data (host_in_data),
        .host_data    (host_data),
        .host_valid   (host_valid),
        .host_ready   (host_ready),
        .count        (count),
        .full         (full),
        .overflow     (overflow),
        .ovf_clear    (ovf_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        cpu_out_data  = d;
        cpu_out_write = 1'b1;
        tick();
        cpu_out_write = 1'b0;
    endtask

    initial begin
        reset         = 1'b0;
        cpu_out_data  = '0;
        cpu_out_write = 1'b0;
        host_in_load  = 1'b0;
        host_in_data  = '0;
        host_ready    = 1'b0;
        ovf_clear     = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(host_valid), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_in", 32'(cpu_in_data), 32'd0);
        chk("rst_hdata", 32'(host_data), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        reset = 1'b1;
        tick();
        chk("post_rst_count", 32'(count), 32'd0);

        // Single push and pop
        push(8'd15);
        chk("one_valid", 32'(host_valid), 32'd1);
        chk("one_data", 32'(host_data), 32'd15);
        chk("one_count", 32'(count), 32'd1);
        host_ready = 1'b1;
        tick();
        host_ready = 1'b0;
        chk("one_pop_valid", 32'(host_valid), 32'd0);
        chk("one_pop_count", 32'(count), 32'd0);
        chk("one_pop_hdata", 32'(host_data), 32'd0);

        // Fill, overflow, drain, clear
        for (int i = 1; i <= 4; i++) push(8'(i));
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd4);
        push(8'd5);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd4);
        host_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_valid", 32'(host_valid), 32'd1);
            chk("drain_data", 32'(host_data), 32'(i));
            tick();
        end
        host_ready = 1'b0;
        chk("drain_empty", 32'(host_valid), 32'd0);
        chk("drain_ovf_sticky", 32'(overflow), 32'd1);
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Full with simultaneous push and pop
        for (int i = 1; i <= 4; i++) push(8'(i));
        chk("fill2_full", 32'(full), 32'd1);
        cpu_out_data  = 8'd9;
        cpu_out_write = 1'b1;
        host_ready    = 1'b1;
        tick();
        cpu_out_write = 1'b0;
        host_ready    = 1'b0;
        chk("pp_count", 32'(count), 32'd4);
        chk("pp_ovf", 32'(overflow), 32'd0);
        chk("pp_head", 32'(host_data), 32'd2);
        host_ready = 1'b1;
        chk("pp_drain0", 32'(host_data), 32'd2);
        tick();
        chk("pp_drain1", 32'(host_data), 32'd3);
        tick();
        chk("pp_drain2", 32'(host_data), 32'd4);
        tick();
        chk("pp_drain3", 32'(host_data), 32'd9);
        tick();
        chk("pp_empty", 32'(count), 32'd0);
        // host_ready while empty is ignored
        tick();
        host_ready = 1'b0;
        chk("empty_ready_count", 32'(count), 32'd0);
        chk("empty_ready_valid", 32'(host_valid), 32'd0);

        // Drop on the same edge as ovf_clear: set wins
        for (int i = 10; i <= 13; i++) push(8'(i));
        push(8'd14);
        chk("ovf2_set", 32'(overflow), 32'd1);
        ovf_clear = 1'b1;
        push(8'd15);
        ovf_clear = 1'b0;
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        chk("ovf_set_wins_cnt", 32'(count), 32'd4);
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        chk("ovf2_clear", 32'(overflow), 32'd0);
        host_ready = 1'b1;
        for (int i = 10; i <= 13; i++) begin
            chk("drain3_data", 32'(host_data), 32'(i));
            tick();
        end
        host_ready = 1'b0;
        chk("drain3_empty", 32'(count), 32'd0);

        // cpu_in_data load and hold
        host_in_load = 1'b1;
        host_in_data = 8'd5;
        tick();
        host_in_load = 1'b0;
        host_in_data = 8'h77;
        chk("in_load", 32'(cpu_in_data), 32'd5);
        tick();
        chk("in_hold", 32'(cpu_in_data), 32'd5);

        // Reset mid-drain with 3 bytes queued
        push(8'd21);
        push(8'd22);
        push(8'd23);
        chk("q3_count", 32'(count), 32'd3);
        host_ready = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", 32'(host_valid), 32'd0);
        chk("arst_in", 32'(cpu_in_data), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_hdata", 32'(host_data), 32'd0);
        host_ready = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // Long OutWrite pulse
        cpu_out_data  = 8'd15;
        cpu_out_write = 1'b1;
        tick();
        tick();
        tick();
        cpu_out_write = 1'b0;
`ifdef MP8_OUT_EDGE_EN
        chk("long_pulse_count", 32'(count), 32'd1);
`else
        chk("long_pulse_count", 32'(count), 32'd3);
`endif
        host_ready = 1'b1;
        for (int i = 0; i < 4 && host_valid; i++) begin
            chk("long_pulse_data", 32'(host_data), 32'd15);
            tick();
        end
        host_ready = 1'b0;
        chk("long_pulse_empty", 32'(count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
